// File: rtl/game_over_check_pkg.sv
// Shared board/piece constants and types for the top-out checker.
package game_over_check_pkg;

  localparam int unsigned BOARD_ROWS = 23;
  localparam int unsigned PIECE_DIM  = 4;
  localparam int unsigned PIECE_BITS = PIECE_DIM * PIECE_DIM;
  localparam int unsigned POS_W      = 5;
  localparam int unsigned ROW_W      = 6;
  localparam int unsigned RIDX_W     = 2;

  // Bit 4*r+c is row r, column c; index 0 is row0/col0 (the literal's MSB).
  typedef logic [0:PIECE_BITS-1] piece_t;

endpackage

// File: rtl/game_over_check_if.sv
// Piece-check bus between placement logic (master) and the top-out checker (slave).
interface game_over_check_if;
  import game_over_check_pkg::*;

  logic                 check;
  logic                 clear;
  logic [POS_W-1:0]     pos_y;
  piece_t               float;
  logic                 overflow;
  logic                 game_over;

  modport master (
    output check, clear, pos_y, float,
    input  overflow, game_over
  );

  modport slave (
    input  check, clear, pos_y, float,
    output overflow, game_over
  );

endinterface

// File: rtl/game_over_check_row_check.sv
// One piece row: flags an occupied row whose board coordinate lies below the playfield.
module goc_row_check
  import game_over_check_pkg::*;
(
  input  logic [PIECE_DIM-1:0] row_bits,
  input  logic [POS_W-1:0]     pos_y,
  input  logic [RIDX_W-1:0]    row_idx,
  output logic                 row_out
);

  logic [ROW_W-1:0] y_row;

  // Widened so pos_y = 31 plus row 3 cannot wrap back onto the board.
  assign y_row   = ROW_W'(pos_y) + ROW_W'(row_idx);
  assign row_out = (|row_bits) && (y_row >= ROW_W'(BOARD_ROWS));

endmodule

// File: rtl/game_over_check.sv
// Top-out detector: combinational overflow plus registered game_over flag.
// Define GOC_STICKY_EN to make game_over latch until clear or reset.
module game_over_check
  import game_over_check_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  game_over_check_if.slave   bus
);

  logic [PIECE_DIM-1:0] row_out;
  logic                 go_next;
  logic                 go_q;

  for (genvar r = 0; r < PIECE_DIM; r++) begin : g_row
    goc_row_check u_row (
      .row_bits (bus.float[r*PIECE_DIM +: PIECE_DIM]),
      .pos_y    (bus.pos_y),
      .row_idx  (RIDX_W'(r)),
      .row_out  (row_out[r])
    );
  end

  assign bus.overflow = |row_out;

  // clear wins over check; otherwise hold.
  always_comb begin
    go_next = go_q;
    if (bus.clear) begin
      go_next = 1'b0;
    end else if (bus.check) begin
`ifdef GOC_STICKY_EN
      go_next = go_q | bus.overflow;
`else
      go_next = bus.overflow;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) go_q <= 1'b0;
    else        go_q <= go_next;
  end

  assign bus.game_over = go_q;

endmodule

// File: tb/tb_game_over_check.sv
// Directed bench for game_over_check; expectations follow GOC_STICKY_EN when defined.
module tb_game_over_check;
  import game_over_check_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic go_exp;

  game_over_check_if bus ();

  game_over_check dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check overflow immediately and game_over after the edge.
  task automatic step(input string tag, input logic [4:0] p, input logic [15:0] f,
                      input logic chk, input logic clr, input logic exp_ovf);
    @(negedge clk);
    bus.pos_y = p;
    bus.float = f;
    bus.check = chk;
    bus.clear = clr;
    #1 check_eq({tag, "_ovf"}, bus.overflow, exp_ovf);
    if (clr)
      go_exp = 1'b0;
    else if (chk) begin
`ifdef GOC_STICKY_EN
      go_exp = go_exp | exp_ovf;
`else
      go_exp = exp_ovf;
`endif
    end
    @(posedge clk);
    #1 check_eq({tag, "_go"}, bus.game_over, go_exp);
    bus.check = 1'b0;
    bus.clear = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    go_exp    = 1'b0;
    rst_n     = 1'b0;
    bus.check = 1'b0;
    bus.clear = 1'b0;
    bus.pos_y = '0;
    bus.float = '0;
    #12 check_eq("reset_go", bus.game_over, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Row boundary sweep: each occupied row lands exactly on or past row 22.
    step("p23_empty", 5'd23, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("p23_row0",  5'd23, 16'h4000, 1'b1, 1'b0, 1'b1);
    step("p22_row0",  5'd22, 16'hF000, 1'b1, 1'b0, 1'b0);
    step("p22_row1",  5'd22, 16'hF400, 1'b1, 1'b0, 1'b1);
    step("p21_row01", 5'd21, 16'hFF00, 1'b1, 1'b0, 1'b0);
    step("p21_row2",  5'd21, 16'hFF40, 1'b1, 1'b0, 1'b1);
    step("p20_row02", 5'd20, 16'hFFF0, 1'b1, 1'b0, 1'b0);
    step("p20_row3",  5'd20, 16'hFFF4, 1'b1, 1'b0, 1'b1);
    step("p19_full",  5'd19, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step("p31_empty", 5'd31, 16'h0000, 1'b1, 1'b0, 1'b0);
    step("p31_col3",  5'd31, 16'h0001, 1'b1, 1'b0, 1'b1);
    step("p0_full",   5'd0,  16'hFFFF, 1'b1, 1'b0, 1'b0);

    // No strobe: overflow visible, flag holds.
    step("hold_set",  5'd23, 16'h8000, 1'b1, 1'b0, 1'b1);
    step("hold_nochk",5'd19, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step("hold_nochk2",5'd19,16'hFFFF, 1'b0, 1'b0, 1'b0);
    check_eq("hold_const", bus.game_over, 1'b1);

    // Safe check after top-out: sticky keeps 1, non-sticky drops to 0.
    step("after_safe",5'd19, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step("reset_set", 5'd23, 16'h8000, 1'b1, 1'b0, 1'b1);
    step("clear",     5'd19, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    step("reset_set2",5'd23, 16'h8000, 1'b1, 1'b0, 1'b1);
    step("clr_chk",   5'd23, 16'h8000, 1'b1, 1'b1, 1'b1);
    step("clr_idle",  5'd0,  16'h0000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle.
    step("async_set", 5'd24, 16'h0100, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst", bus.game_over, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    go_exp = 1'b0;
    step("post_rst",  5'd23, 16'h0000, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
